// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//   Hazard / stall control for the 5-stage MIPS pipeline, sitting beside ID.
//   Detects load-use, non-forwarded RAW and ID-resolved branch hazards, holds
//   load-use stalls for LOAD_USE_CYCLES cycles, freezes the whole pipe while
//   data memory is not ready (resuming the interrupted state afterwards),
//   flushes IF/ID on a taken branch, and counts bubble cycles (saturating).
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   src1_i/src2_i (+_used)  ID source registers and whether they are read
//   is_branch_i             ID holds a register-comparing branch
//   branch_taken_i          branch outcome (valid with is_branch_i)
//   Exe_Dest_i/Exe_WB_i/Exe_Mem_Read_En_i  EXE destination, write-back, load
//   Mem_Dest_i/Mem_WB_i     MEM destination, write-back
//   mem_ready_i             data memory ready (0 = wait)
//   hazard_Detected_o       ID stall active this cycle
//   pc_en_o, ifid_en_o      PC / IF/ID load enables
//   ifid_flush_o            clear IF/ID (taken branch)
//   idex_bubble_o           load NOP into ID/EX
//   freeze_all_o            hold every pipeline register
//   stall_cycles_o          saturating count of bubble cycles
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
   parameter int unsigned REG_ADDR_W      = 5,
   parameter bit          FORWARD_EN      = 1'b1,
   parameter int unsigned LOAD_USE_CYCLES = 1,
   parameter int unsigned STAT_W          = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] src1_i,
   input  logic [REG_ADDR_W-1:0] src2_i,
   input  logic                  src1_used_i,
   input  logic                  src2_used_i,
   input  logic                  is_branch_i,
   input  logic                  branch_taken_i,
   input  logic [REG_ADDR_W-1:0] Exe_Dest_i,
   input  logic                  Exe_WB_i,
   input  logic                  Exe_Mem_Read_En_i,
   input  logic [REG_ADDR_W-1:0] Mem_Dest_i,
   input  logic                  Mem_WB_i,
   input  logic                  mem_ready_i,
   output logic                  hazard_Detected_o,
   output logic                  pc_en_o,
   output logic                  ifid_en_o,
   output logic                  ifid_flush_o,
   output logic                  idex_bubble_o,
   output logic                  freeze_all_o,
   output logic [STAT_W-1:0]     stall_cycles_o
);

   typedef enum logic [1:0] {RUN = 2'd0, LU_STALL = 2'd1, MEM_FREEZE = 2'd2} state_e;

   // The hazard cycle itself is the first stall cycle, so the counter is
   // loaded with the remaining cycles only.
   localparam logic [3:0] LU_RELOAD = 4'(LOAD_USE_CYCLES - 1);

   state_e            state_q, state_d;
   state_e            ret_q, ret_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [STAT_W-1:0] stat_q, stat_d;

   logic exe_match, mem_match;
   logic lu_haz, raw_haz, br_haz, stall;

   // Register 0 is hard-wired, so a write to it never creates a dependency.
   function automatic logic reg_match(input logic [REG_ADDR_W-1:0] s,
                                      input logic [REG_ADDR_W-1:0] d,
                                      input logic                  used);
      return used && (s == d) && (d != '0);
   endfunction

   assign exe_match = reg_match(src1_i, Exe_Dest_i, src1_used_i) ||
                      reg_match(src2_i, Exe_Dest_i, src2_used_i);
   assign mem_match = reg_match(src1_i, Mem_Dest_i, src1_used_i) ||
                      reg_match(src2_i, Mem_Dest_i, src2_used_i);

   assign lu_haz  = Exe_WB_i && Exe_Mem_Read_En_i && exe_match;
   assign raw_haz = FORWARD_EN ? 1'b0 : ((Exe_WB_i && exe_match) || (Mem_WB_i && mem_match));
   // Branches compare in ID, ahead of the forwarding paths, so any pending
   // producer in EXE or MEM must drain first.
   assign br_haz  = is_branch_i && ((Exe_WB_i && exe_match) || (Mem_WB_i && mem_match));

   // Output equations: freeze dominates stall, stall dominates flush.
   always_comb begin
      stall             = (state_q == LU_STALL) ||
                          ((state_q == RUN) && (lu_haz || raw_haz || br_haz));
      freeze_all_o      = !mem_ready_i;
      hazard_Detected_o = stall;
      pc_en_o           = !stall && !freeze_all_o;
      ifid_en_o         = !stall && !freeze_all_o;
      idex_bubble_o     = stall && !freeze_all_o;
      ifid_flush_o      = is_branch_i && branch_taken_i && !stall && !freeze_all_o;
      stall_cycles_o    = stat_q;
   end

   // Next-state logic. A memory wait suspends whatever state we are in and
   // records it in ret so the stall resumes with its count intact.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (!mem_ready_i) begin
               state_d = MEM_FREEZE;
               ret_d   = RUN;
            end else if (lu_haz && (LOAD_USE_CYCLES > 1)) begin
               state_d = LU_STALL;
               cnt_d   = LU_RELOAD;
            end
         end
         LU_STALL: begin
            if (!mem_ready_i) begin
               state_d = MEM_FREEZE;
               ret_d   = LU_STALL;
            end else if (cnt_q == 4'd1) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         MEM_FREEZE: begin
            if (mem_ready_i) state_d = ret_q;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      stat_d = stat_q;
      if (idex_bubble_o && (stat_q != {STAT_W{1'b1}})) stat_d = stat_q + STAT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         ret_q   <= RUN;
         cnt_q   <= 4'd0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         stat_q  <= stat_d;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller. Four instances share one stimulus:
//   0: FORWARD_EN=1 LOAD_USE_CYCLES=1 STAT_W=16
//   1: FORWARD_EN=1 LOAD_USE_CYCLES=3 STAT_W=16
//   2: FORWARD_EN=0 LOAD_USE_CYCLES=3 STAT_W=16
//   3: FORWARD_EN=1 LOAD_USE_CYCLES=3 STAT_W=2  (counter saturation)
// A behavioural model (owed stall cycles + frozen flag) is compared on every
// negedge; directed literal checks pin the model.
module tb_hazard_stall_controller;
   localparam logic [3:0] FWB = 4'b1011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, src1_used, src2_used, is_branch, branch_taken;
   logic       Exe_WB, Exe_Mem_Read_En, Mem_WB, mem_ready;
   logic [4:0] src1, src2, Exe_Dest, Mem_Dest;

   logic        hd[4], pc[4], ie[4], fl[4], bb[4], fz[4];
   logic [15:0] sc[4];

   int checks = 0, failures = 0;
   bit started = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int SW = (g == 3) ? 2 : 16;
      logic [SW-1:0] sc_w;
      hazard_stall_controller #(.REG_ADDR_W(5), .FORWARD_EN(FWB[g]),
                                .LOAD_USE_CYCLES((g == 0) ? 1 : 3), .STAT_W(SW)) u_dut (
         .clk_i(clk), .rst_i(rst), .src1_i(src1), .src2_i(src2),
         .src1_used_i(src1_used), .src2_used_i(src2_used),
         .is_branch_i(is_branch), .branch_taken_i(branch_taken),
         .Exe_Dest_i(Exe_Dest), .Exe_WB_i(Exe_WB), .Exe_Mem_Read_En_i(Exe_Mem_Read_En),
         .Mem_Dest_i(Mem_Dest), .Mem_WB_i(Mem_WB), .mem_ready_i(mem_ready),
         .hazard_Detected_o(hd[g]), .pc_en_o(pc[g]), .ifid_en_o(ie[g]),
         .ifid_flush_o(fl[g]), .idex_bubble_o(bb[g]), .freeze_all_o(fz[g]),
         .stall_cycles_o(sc_w));
      assign sc[g] = 16'(sc_w);
   end

   task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", name, k, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int pend[4];   // stall cycles still owed after the current one
   bit frz[4];    // pipe suspended by a memory wait
   int stat[4];

   function automatic bit reads(input logic [4:0] r);
      return (r != 0) && ((src1_used && src1 == r) || (src2_used && src2 == r));
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         bit lu, haz, e_hd, e_pc, e_fl, e_bb;
         int lu_n, smax;
         lu_n = (k == 0) ? 1 : 3;
         smax = (k == 3) ? 3 : 65535;
         lu   = Exe_WB && Exe_Mem_Read_En && reads(Exe_Dest);
         haz  = lu || (is_branch && ((Exe_WB && reads(Exe_Dest)) || (Mem_WB && reads(Mem_Dest))));
         if (!FWB[k]) haz = haz || (Exe_WB && reads(Exe_Dest)) || (Mem_WB && reads(Mem_Dest));
         e_hd = !frz[k] && (pend[k] > 0 || haz);
         e_pc = !e_hd && mem_ready;
         e_bb = e_hd && mem_ready;
         e_fl = is_branch && branch_taken && e_pc;
         if (started) begin
            chk("hazard_Detected", k, 16'(hd[k]), 16'(e_hd));
            chk("pc_en", k, 16'(pc[k]), 16'(e_pc));
            chk("ifid_en", k, 16'(ie[k]), 16'(e_pc));
            chk("ifid_flush", k, 16'(fl[k]), 16'(e_fl));
            chk("idex_bubble", k, 16'(bb[k]), 16'(e_bb));
            chk("freeze_all", k, 16'(fz[k]), 16'(!mem_ready));
            chk("stall_cycles", k, sc[k], 16'(stat[k]));
         end
         if (rst) begin
            pend[k] = 0; frz[k] = 0; stat[k] = 0;
         end else begin
            if (e_bb && stat[k] < smax) stat[k]++;
            if (frz[k]) begin
               if (mem_ready) frz[k] = 0;
            end else if (!mem_ready) frz[k] = 1;
            else if (pend[k] > 0) pend[k]--;
            else if (lu) pend[k] = lu_n - 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      src1 = 0; src2 = 0; src1_used = 0; src2_used = 0; is_branch = 0; branch_taken = 0;
      Exe_Dest = 0; Exe_WB = 0; Exe_Mem_Read_En = 0; Mem_Dest = 0; Mem_WB = 0; mem_ready = 1;
   endtask

   task automatic load_use();   // EXE: lw $3; ID reads $3 on src1
      Exe_WB = 1; Exe_Mem_Read_En = 1; Exe_Dest = 3; src1 = 3; src1_used = 1;
   endtask

   task automatic clear_exe();
      Exe_WB = 0; Exe_Mem_Read_En = 0; Exe_Dest = 0;
   endtask

   int nb, np;

   initial begin
      idle(); rst = 1;
      tick(); started = 1;
      tick(); rst = 0;
      #1;
      chk("rst_stall_cycles", 1, sc[1], 16'd0);
      chk("rst_pc_en", 1, 16'(pc[1]), 16'd1);
      tick();

      // load-use: 1 bubble on inst0, 3 on the others
      load_use(); #1;
      chk("lu1_hd", 0, 16'(hd[0]), 16'd1);
      chk("lu1_pc_en", 0, 16'(pc[0]), 16'd0);
      chk("lu1_bubble", 0, 16'(bb[0]), 16'd1);
      tick(); clear_exe(); #1;
      chk("lu1_release", 0, 16'(pc[0]), 16'd1);
      chk("lu3_held", 1, 16'(hd[1]), 16'd1);
      tick(); tick(); #1;
      chk("lu3_release", 1, 16'(pc[1]), 16'd1);
      chk("lu1_count", 0, sc[0], 16'd1);
      chk("lu3_count", 1, sc[1], 16'd3);
      chk("sat_count_a", 3, sc[3], 16'd3);
      load_use(); tick(); clear_exe(); tick(); tick(); tick(); #1;
      chk("lu3_count2", 1, sc[1], 16'd6);
      chk("sat_count_b", 3, sc[3], 16'd3);

      // no-stall cases: destination $0, unused src2
      idle(); Exe_WB = 1; Exe_Mem_Read_En = 1; src1_used = 1; #1;
      chk("r0_no_stall", 1, 16'(hd[1]), 16'd0);
      chk("r0_no_stall", 2, 16'(hd[2]), 16'd0);
      tick(); src1 = 5; src2 = 3; src2_used = 0; Exe_Dest = 3; #1;
      chk("unused_src2", 1, 16'(hd[1]), 16'd0);
      chk("unused_src2", 2, 16'(hd[2]), 16'd0);
      tick(); idle(); tick();

      // memory wait in the 2nd load-use stall cycle
      nb = 0; np = 0;
      for (int c = 0; c < 7; c++) begin
         if (c == 0) load_use(); else clear_exe();
         mem_ready = !(c == 1 || c == 2);
         #1;
         if (c < 6) begin nb += int'(bb[1]); np += int'(!pc[1]); end
         if (c == 1) begin
            chk("frz_freeze", 1, 16'(fz[1]), 16'd1);
            chk("frz_no_bubble", 1, 16'(bb[1]), 16'd0);
         end
         if (c == 6) chk("frz_done", 1, 16'(pc[1]), 16'd1);
         tick();
      end
      chk("frz_bubbles", 1, 16'(nb), 16'd3);
      chk("frz_pc_hold", 1, 16'(np), 16'd5);

      // load-use while memory waits in RUN
      idle(); load_use(); mem_ready = 0; tick(); clear_exe(); tick(); mem_ready = 1; tick(); tick();

      // non-forwarded RAW from MEM
      idle(); Mem_WB = 1; Mem_Dest = 7; src2 = 7; src2_used = 1; #1;
      chk("raw_nofwd", 2, 16'(hd[2]), 16'd1);
      chk("raw_fwd", 1, 16'(hd[1]), 16'd0);
      tick(); idle(); #1;
      chk("raw_one_cycle", 2, 16'(hd[2]), 16'd0);
      tick();

      // taken branch waiting on EXE producer, then flush
      is_branch = 1; branch_taken = 1; Exe_WB = 1; Exe_Dest = 4; src1 = 4; src1_used = 1; #1;
      chk("br_stall", 1, 16'(hd[1]), 16'd1);
      chk("br_no_flush", 1, 16'(fl[1]), 16'd0);
      tick(); Exe_WB = 0; #1;
      chk("br_flush", 1, 16'(fl[1]), 16'd1);
      chk("br_pc_en", 1, 16'(pc[1]), 16'd1);
      tick(); mem_ready = 0; tick(); mem_ready = 1; branch_taken = 0; tick(); idle(); tick();

      // reset in LU_STALL with cnt=2
      load_use(); tick(); idle(); rst = 1; #1;
      chk("rst_mid_stall_pre", 1, 16'(hd[1]), 16'd1);
      tick(); rst = 0; #1;
      chk("rst_mid_hd", 1, 16'(hd[1]), 16'd0);
      chk("rst_mid_bubble", 1, 16'(bb[1]), 16'd0);
      chk("rst_mid_count", 1, sc[1], 16'd0);
      chk("rst_mid_count", 3, sc[3], 16'd0);
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Parametrised hazard and stall controller for the 5-stage MIPS pipeline; next generation of the combinational hazard detector.
- Detects load-use, non-forwarded RAW and ID-resolved branch hazards.
- Adds multi-cycle load-use stalls, a memory-wait freeze with state resume, gated IF/ID flush on taken branch, and a saturating stall-cycle statistic.
- Sits beside the ID stage and drives the PC, IF/ID and ID/EX register controls.

Parameters:
- REG_ADDR_W, 5, register-address width.
- FORWARD_EN, 1, 1 = forwarding unit present (stall only on load-use and branch); 0 = stall on any EXE/MEM write-back match.
- LOAD_USE_CYCLES, 1, total stall cycles per load-use hazard; legal range 1..15.
- STAT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- src1  in  REG_ADDR_W  ID source register 1.
- src2  in  REG_ADDR_W  ID source register 2.
- src1_used  in  1  ID instruction reads src1.
- src2_used  in  1  ID instruction reads src2 (0 for immediate forms).
- is_branch  in  1  ID instruction is a register-comparing branch, resolved in ID.
- branch_taken  in  1  ID branch outcome, valid when is_branch.
- Exe_Dest  in  REG_ADDR_W  destination register in EXE.
- Exe_WB  in  1  EXE instruction writes back.
- Exe_Mem_Read_En  in  1  EXE instruction is a load.
- Mem_Dest  in  REG_ADDR_W  destination register in MEM.
- Mem_WB  in  1  MEM instruction writes back.
- mem_ready  in  1  data memory ready; 0 = memory wait.
- hazard_Detected  out  1  ID stall active this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID (taken branch).
- idex_bubble  out  1  load NOP into ID/EX.
- freeze_all  out  1  hold every pipeline register.
- stall_cycles  out  STAT_W  saturating count of bubble cycles.

Behaviour:
- Match definitions:
  - match(s, d) = (s == d) && (d != 0) && s_used.
  - Register 0 never causes a hazard.
- lu_haz = Exe_WB && Exe_Mem_Read_En && (match(src1, Exe_Dest) || match(src2, Exe_Dest)).
- raw_haz:
  - FORWARD_EN=0: (Exe_WB && any match on Exe_Dest) || (Mem_WB && any match on Mem_Dest).
  - FORWARD_EN=1: raw_haz = 0.
- br_haz = is_branch && ((Exe_WB && any match on Exe_Dest) || (Mem_WB && any match on Mem_Dest)).
- FSM states RUN, LU_STALL, MEM_FREEZE; 4-bit counter cnt; return-state register ret.
- Outputs are combinational from state and inputs:
  - stall = (state==LU_STALL) || (state==RUN && (lu_haz || raw_haz || br_haz)).
  - freeze_all = !mem_ready in any state.
  - hazard_Detected = stall.
  - pc_en = ifid_en = !stall && !freeze_all.
  - idex_bubble = stall && !freeze_all.
  - ifid_flush = is_branch && branch_taken && !stall && !freeze_all.
- RUN transitions:
  - !mem_ready -> MEM_FREEZE, ret=RUN.
  - else lu_haz && LOAD_USE_CYCLES>1 -> LU_STALL, cnt=LOAD_USE_CYCLES-1.
  - else stay in RUN.
- LU_STALL transitions:
  - !mem_ready -> MEM_FREEZE, ret=LU_STALL, cnt held.
  - else cnt==1 -> RUN.
  - else cnt-1, stay in LU_STALL.
  - Hazard inputs are ignored in LU_STALL.
- MEM_FREEZE: mem_ready=1 -> ret, with cnt unchanged; otherwise stay.
- stall_cycles increments on every cycle with idex_bubble=1, saturating at all-ones.
- Load-use total stall = LOAD_USE_CYCLES non-frozen cycles; frozen cycles do not count toward it.
- Reset: state=RUN, cnt=0, ret=RUN, stall_cycles=0.
  - Reset mid-stall or mid-freeze aborts immediately.
  - The outputs then follow the RUN equations with the current inputs.
- Simultaneous events: freeze dominates stall, which dominates flush. A taken branch under stall/freeze is re-presented by the held ID stage.

Test Plan:
- LOAD_USE_CYCLES=1: EXE lw $3 (Exe_WB=1, Exe_Mem_Read_En=1, Exe_Dest=3); ID src1=3, src1_used=1 -> hazard_Detected=1, pc_en=0, idex_bubble=1 for exactly 1 cycle; stall_cycles=1.
- LOAD_USE_CYCLES=3, same hazard -> 3 consecutive bubble cycles, then pc_en=1; stall_cycles=3. Repeat with Exe_Dest=0 or src2_used=0 & src2=3 -> no stall.
- LOAD_USE_CYCLES=3: drop mem_ready for 2 cycles during the 2nd stall cycle:
  - freeze_all=1, idex_bubble=0 for those cycles;
  - resume in LU_STALL;
  - total bubbles=3, total pc_en=0 cycles=5.
- FORWARD_EN=0: Mem_WB=1, Mem_Dest=7; ID src2=7, src2_used=1 -> 1-cycle stall. Same stimulus with FORWARD_EN=1 -> no stall.
- is_branch=1, branch_taken=1, Exe_WB=1, Exe_Dest=4, src1=4:
  - ifid_flush=0, stall=1.
  - Next cycle with Exe_WB=0: ifid_flush=1, pc_en=1.
- rst asserted while in LU_STALL with cnt=2 -> next cycle state RUN, stall_cycles=0, no residual bubble.
